// File: rtl/warp_dispatch_if.sv
// Block-to-warp dispatch bus: block assignment from the kernel dispatcher,
// warp descriptor handshake to the warp pipeline, and retire/status feedback.
interface warp_dispatch_if #(
  parameter int WARP_SIZE = 32,
  parameter int WARP_ID_W = 8
);
  logic                 start;
  logic [31:0]          block_id;
  logic [31:0]          block_dim;
  logic [31:0]          num_threads;
  logic                 warp_valid;
  logic                 warp_ready;
  logic [WARP_ID_W-1:0] warp_id;
  logic [31:0]          warp_base_tid;
  logic [WARP_SIZE-1:0] warp_mask;
  logic                 warp_retire;
  logic                 busy;
  logic                 done;

  modport master (
    output start, block_id, block_dim, num_threads, warp_ready, warp_retire,
    input  warp_valid, warp_id, warp_base_tid, warp_mask, busy, done
  );

  modport slave (
    input  start, block_id, block_dim, num_threads, warp_ready, warp_retire,
    output warp_valid, warp_id, warp_base_tid, warp_mask, busy, done
  );
endinterface

// File: rtl/warp_dispatch.sv
// Splits one thread block into WARP_SIZE-thread warps, issues them with an
// in-flight cap and signals done once all retire. WARP_DISPATCH_STATS_EN adds stall_cycles.
module warp_dispatch #(
  parameter int WARP_SIZE    = 32,
  parameter int MAX_INFLIGHT = 4,
  parameter int WARP_ID_W    = 8
) (
  input  logic           clk,
  input  logic           rst,
  warp_dispatch_if.slave bus
`ifdef WARP_DISPATCH_STATS_EN
  ,
  output logic [31:0]    stall_cycles
`endif
);
  typedef enum logic [2:0] {IDLE, SETUP, ISSUE, DRAIN, DONE} state_t;

  localparam int                   WS_LOG  = $clog2(WARP_SIZE);
  localparam logic [31:0]          WS      = 32'(WARP_SIZE);
  localparam logic [31:0]          NW_MAX  = 32'((64'd1 << WARP_ID_W) - 64'd1);
  localparam logic [WARP_ID_W-1:0] MAX_INF = WARP_ID_W'(MAX_INFLIGHT);

  state_t               state_q, state_d;
  logic [31:0]          bid_q, bid_d, bdim_q, bdim_d, nthr_q, nthr_d;
  logic [31:0]          base_q, base_d, eff_q, eff_d;
  logic [WARP_ID_W-1:0] nwarps_q, nwarps_d, issued_q, issued_d;
  logic [WARP_ID_W-1:0] inflight_q, inflight_d, retired_q, retired_d;
  logic                 valid_q, valid_d, busy_q, busy_d, done_q, done_d;
  logic [WARP_ID_W-1:0] wid_q, wid_d;
  logic [31:0]          wbase_q, wbase_d;
  logic [WARP_SIZE-1:0] wmask_q, wmask_d;

  logic [31:0]          setup_base, setup_avail, setup_eff, setup_nw32;
  logic [WARP_ID_W-1:0] setup_nw;
  logic                 xfer, ret;

  // Lanes still owed to warp k; only the tail warp sees fewer than WARP_SIZE.
  // Past the tail the subtraction wraps large, which also yields all ones.
  function automatic logic [WARP_SIZE-1:0] lane_mask(input logic [31:0] eff,
                                                     input logic [WARP_ID_W-1:0] k);
    logic [31:0] rem;
    rem = eff - 32'(k) * WS;
    if (rem >= WS) lane_mask = '1;
    else           lane_mask = ~({WARP_SIZE{1'b1}} << rem);
  endfunction

  always_comb begin
    setup_base  = bid_q * bdim_q;
    setup_avail = nthr_q - setup_base;
    if (setup_base >= nthr_q)      setup_eff = '0;
    else if (bdim_q < setup_avail) setup_eff = bdim_q;
    else                           setup_eff = setup_avail;
    setup_nw32 = (setup_eff >> WS_LOG) + {31'd0, (setup_eff & (WS - 32'd1)) != 32'd0};
    setup_nw   = (setup_nw32 > NW_MAX) ? '1 : WARP_ID_W'(setup_nw32);
  end

  always_comb begin
    state_d  = state_q;
    bid_d    = bid_q;
    bdim_d   = bdim_q;
    nthr_d   = nthr_q;
    base_d   = base_q;
    eff_d    = eff_q;
    nwarps_d = nwarps_q;
    valid_d  = valid_q;
    busy_d   = busy_q;
    done_d   = done_q;
    wid_d    = wid_q;
    wbase_d  = wbase_q;
    wmask_d  = wmask_q;

    xfer       = valid_q && bus.warp_ready;
    ret        = bus.warp_retire && (inflight_q != '0);
    inflight_d = inflight_q + WARP_ID_W'(xfer) - WARP_ID_W'(ret);
    issued_d   = issued_q + WARP_ID_W'(xfer);
    retired_d  = retired_q + WARP_ID_W'(ret);

    case (state_q)
      IDLE: if (bus.start) begin
        state_d   = SETUP;
        bid_d     = bus.block_id;
        bdim_d    = bus.block_dim;
        nthr_d    = bus.num_threads;
        busy_d    = 1'b1;
        issued_d  = '0;
        retired_d = '0;
      end
      SETUP: begin
        base_d   = setup_base;
        eff_d    = setup_eff;
        nwarps_d = setup_nw;
        wid_d    = '0;
        wbase_d  = setup_base;
        wmask_d  = lane_mask(setup_eff, '0);
        if (setup_nw == '0) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          state_d = ISSUE;
          valid_d = inflight_d < MAX_INF;
        end
      end
      ISSUE: begin
        // Descriptor only advances on a transfer, so it stays stable under backpressure.
        if (xfer) begin
          wid_d   = issued_d;
          wbase_d = base_q + 32'(issued_d) * WS;
          wmask_d = lane_mask(eff_q, issued_d);
        end
        if (xfer && issued_d == nwarps_q) begin
          valid_d = 1'b0;
          state_d = DRAIN;
        end else begin
          valid_d = (valid_q && !xfer) || (inflight_d < MAX_INF);
        end
      end
      DRAIN: if (retired_d == nwarps_q) begin
        state_d = DONE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end
      DONE: if (!bus.start) begin
        state_d = IDLE;
        done_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      bid_q      <= '0;
      bdim_q     <= '0;
      nthr_q     <= '0;
      base_q     <= '0;
      eff_q      <= '0;
      nwarps_q   <= '0;
      issued_q   <= '0;
      inflight_q <= '0;
      retired_q  <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      wid_q      <= '0;
      wbase_q    <= '0;
      wmask_q    <= '0;
    end else begin
      state_q    <= state_d;
      bid_q      <= bid_d;
      bdim_q     <= bdim_d;
      nthr_q     <= nthr_d;
      base_q     <= base_d;
      eff_q      <= eff_d;
      nwarps_q   <= nwarps_d;
      issued_q   <= issued_d;
      inflight_q <= inflight_d;
      retired_q  <= retired_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      wid_q      <= wid_d;
      wbase_q    <= wbase_d;
      wmask_q    <= wmask_d;
    end
  end

  assign bus.warp_valid    = valid_q;
  assign bus.warp_id       = wid_q;
  assign bus.warp_base_tid = wbase_q;
  assign bus.warp_mask     = wmask_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;

`ifdef WARP_DISPATCH_STATS_EN
  logic [31:0] stall_q, stall_d;
  logic        stall_ev;

  // Stalls are either pipeline backpressure or the in-flight cap holding issue off.
  always_comb begin
    stall_ev = (valid_q && !bus.warp_ready) ||
               (state_q == ISSUE && !valid_q && inflight_q == MAX_INF);
    stall_d  = stall_q;
    if (state_q == IDLE && bus.start)     stall_d = '0;
    else if (stall_ev && stall_q != '1)   stall_d = stall_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) stall_q <= '0;
    else     stall_q <= stall_d;
  end

  assign stall_cycles = stall_q;
`endif
endmodule

// File: tb/tb_warp_dispatch.sv
// Scoreboard bench for warp_dispatch: expected descriptors are queued from a
// reference model when a block starts and popped on each accepted transfer.
module tb_warp_dispatch;
  localparam int WS   = 32;
  localparam int MAXI = 4;
  localparam int IDW  = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  warp_dispatch_if #(.WARP_SIZE(WS), .WARP_ID_W(IDW)) bus ();
`ifdef WARP_DISPATCH_STATS_EN
  logic [31:0] stall_cycles;
`endif

  warp_dispatch #(.WARP_SIZE(WS), .MAX_INFLIGHT(MAXI), .WARP_ID_W(IDW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef WARP_DISPATCH_STATS_EN
    ,
    .stall_cycles(stall_cycles)
`endif
  );

  typedef struct {
    logic [IDW-1:0] id;
    logic [31:0]    base;
    logic [31:0]    mask;
  } desc_t;

  desc_t exp_q[$];
  int    errors = 0;
  int    checks = 0;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic push_block(input logic [31:0] bid, bdim, nt, output int nw);
    logic [31:0] base, eff, rem;
    desc_t d;
    base = bid * bdim;
    if (base >= nt)        eff = 32'd0;
    else if (nt - base < bdim) eff = nt - base;
    else                   eff = bdim;
    nw = int'((eff + 32'd31) / 32'd32);
    for (int k = 0; k < nw; k++) begin
      d.id   = IDW'(k);
      d.base = base + 32'(k * WS);
      rem    = eff - 32'(k * WS);
      d.mask = (rem >= 32'd32) ? 32'hFFFF_FFFF : ((32'h1 << rem) - 32'h1);
      exp_q.push_back(d);
    end
  endtask

  task automatic sb_compare(input string name);
    desc_t d;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s_unexpected_warp: got id=%0d base=%h, want no transfer", name,
               bus.warp_id, bus.warp_base_tid);
    end else begin
      d = exp_q.pop_front();
      if ({bus.warp_id, bus.warp_base_tid, bus.warp_mask} !== {d.id, d.base, d.mask}) begin
        errors++;
        $display("FAIL %s_desc: got id=%0d base=%h mask=%h, want id=%0d base=%h mask=%h", name,
                 bus.warp_id, bus.warp_base_tid, bus.warp_mask, d.id, d.base, d.mask);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.warp_valid, bus.busy, bus.done, bus.warp_id, bus.warp_base_tid, bus.warp_mask} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%b busy=%b done=%b id=%h base=%h mask=%h, want all 0",
               bus.warp_valid, bus.busy, bus.done, bus.warp_id, bus.warp_base_tid, bus.warp_mask);
    end
`ifdef WARP_DISPATCH_STATS_EN
    checks++;
    if (stall_cycles !== 32'd0) begin
      errors++;
      $display("FAIL reset_stall: got %0d want 0", stall_cycles);
    end
`endif
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Runs one block with ready held high and each warp retiring rdelay cycles after issue.
  task automatic run_block(input string name, input logic [31:0] bid, bdim, nt,
                           input int rdelay, input int exp_nw);
    int nw, c, n_xfer, first_v, done_c, last_ret;
    int ret_q[$];
    push_block(bid, bdim, nt, nw);
    n_xfer = 0; first_v = -1; done_c = -1; last_ret = -1; c = 0;
    bus.block_id = bid; bus.block_dim = bdim; bus.num_threads = nt;
    bus.warp_ready = 1'b1; bus.warp_retire = 1'b0; bus.start = 1'b1;
    while (done_c < 0 && c < 300) begin
      @(negedge clk);
      c++;
      if (c == 1) begin
        checks++;
        if (bus.busy !== 1'b1 || bus.warp_valid !== 1'b0) begin
          errors++;
          $display("FAIL %s_setup: got busy=%b valid=%b, want busy=1 valid=0", name, bus.busy, bus.warp_valid);
        end
      end
      if (bus.warp_valid && first_v < 0) first_v = c;
      if (bus.done) done_c = c;
      bus.warp_retire = (ret_q.size() > 0 && ret_q[0] == c);
      if (bus.warp_retire) begin
        void'(ret_q.pop_front());
        last_ret = c;
      end
      if (bus.warp_valid && bus.warp_ready) begin
        n_xfer++;
        ret_q.push_back(c + rdelay);
        sb_compare(name);
      end
    end
    bus.warp_retire = 1'b0;
    checks++;
    if (done_c < 0) begin
      errors++;
      $display("FAIL %s_timeout: got no done within %0d cycles, want done", name, c);
    end
    checks++;
    if (n_xfer != exp_nw) begin
      errors++;
      $display("FAIL %s_warp_count: got %0d want %0d", name, n_xfer, exp_nw);
    end
    if (exp_nw > 0) begin
      checks++;
      if (first_v != 2) begin
        errors++;
        $display("FAIL %s_issue_latency: got valid at cycle %0d want 2", name, first_v);
      end
      checks++;
      if (done_c != last_ret + 1) begin
        errors++;
        $display("FAIL %s_done_timing: got done at %0d want %0d", name, done_c, last_ret + 1);
      end
    end else begin
      checks++;
      if (first_v != -1 || done_c != 2) begin
        errors++;
        $display("FAIL %s_empty_block: got first_valid=%0d done_at=%0d want -1 and 2", name, first_v, done_c);
      end
    end
    bus.start = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.done, bus.busy} !== 2'b00) begin
      errors++;
      $display("FAIL %s_done_release: got done=%b busy=%b want 0 0", name, bus.done, bus.busy);
    end
    exp_q.delete();
  endtask

  task automatic test_basic();
    run_block("basic", 32'd1, 32'd64, 32'd256, 3, 2);
  endtask

  task automatic test_partial();
    run_block("partial_last", 32'd0, 32'd100, 32'd1000, 3, 4);
    run_block("clipped_block", 32'd1, 32'd128, 32'd200, 3, 3);
  endtask

  task automatic test_empty();
    run_block("zero_dim", 32'd5, 32'd0, 32'd256, 3, 0);
    run_block("past_end", 32'd4, 32'd64, 32'd256, 3, 0);
  endtask

  task automatic test_backpressure();
    int nw, n_xfer, infl, blocked, stall_exp;
    logic [IDW-1:0] hid;
    logic [31:0] hbase, hmask;
    bit fin;
    push_block(32'd0, 32'd256, 32'd1000, nw);
    n_xfer = 0; infl = 0; blocked = 0; stall_exp = 0; fin = 0;
    hid = '0; hbase = '0; hmask = '0;
    bus.block_id = 32'd0; bus.block_dim = 32'd256; bus.num_threads = 32'd1000;
    bus.warp_ready = 1'b0; bus.warp_retire = 1'b0; bus.start = 1'b1;
    for (int c = 1; c <= 60 && !fin; c++) begin
      @(negedge clk);
      if (n_xfer == 5) begin
        fin = 1;
      end else begin
        if (c == 2) begin
          checks++;
          if (bus.warp_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_latency: got valid=%b at cycle 2 want 1", bus.warp_valid);
          end
          hid = bus.warp_id; hbase = bus.warp_base_tid; hmask = bus.warp_mask;
        end
        if (c > 2 && c <= 6) begin
          checks++;
          if ({bus.warp_valid, bus.warp_id, bus.warp_base_tid, bus.warp_mask} !== {1'b1, hid, hbase, hmask}) begin
            errors++;
            $display("FAIL bp_hold: got valid=%b id=%0d base=%h mask=%h want valid=1 id=%0d base=%h mask=%h",
                     bus.warp_valid, bus.warp_id, bus.warp_base_tid, bus.warp_mask, hid, hbase, hmask);
          end
        end
        bus.warp_ready  = (c >= 7);
        bus.warp_retire = 1'b0;
        if (n_xfer == 4 && infl == MAXI) begin
          blocked++;
          checks++;
          if (bus.warp_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_cap: got valid=%b with %0d in flight want 0", bus.warp_valid, infl);
          end
          if (blocked == 3) bus.warp_retire = 1'b1;
        end
        if (c >= 2 && ((bus.warp_valid && !bus.warp_ready) || (!bus.warp_valid && infl == MAXI)))
          stall_exp++;
        if (bus.warp_valid && bus.warp_ready) begin
          n_xfer++;
          infl++;
          sb_compare("bp");
        end
        if (bus.warp_retire) infl--;
      end
    end
    checks++;
    if (n_xfer != 5 || blocked != 3) begin
      errors++;
      $display("FAIL bp_issue_count: got xfers=%0d blocked=%0d want 5 and 3", n_xfer, blocked);
    end
`ifdef WARP_DISPATCH_STATS_EN
    checks++;
    if (stall_cycles !== 32'(stall_exp)) begin
      errors++;
      $display("FAIL bp_stall_cycles: got %0d want %0d", stall_cycles, stall_exp);
    end
`endif
    bus.start = 1'b0; bus.warp_ready = 1'b0; bus.warp_retire = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
  endtask

  task automatic test_rst_mid();
    int nw, n_xfer;
    push_block(32'd0, 32'd256, 32'd1000, nw);
    n_xfer = 0;
    bus.block_id = 32'd0; bus.block_dim = 32'd256; bus.num_threads = 32'd1000;
    bus.warp_ready = 1'b1; bus.warp_retire = 1'b0; bus.start = 1'b1;
    for (int c = 1; c <= 20 && n_xfer < 2; c++) begin
      @(negedge clk);
      if (bus.warp_valid && bus.warp_ready) begin
        n_xfer++;
        sb_compare("rst_mid");
      end
    end
    @(negedge clk);
    rst = 1'b1;
    bus.warp_ready = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.warp_valid, bus.busy, bus.done, bus.warp_id, bus.warp_base_tid, bus.warp_mask} !== '0) begin
      errors++;
      $display("FAIL rst_mid_outputs: got valid=%b busy=%b done=%b id=%h base=%h mask=%h, want all 0",
               bus.warp_valid, bus.busy, bus.done, bus.warp_id, bus.warp_base_tid, bus.warp_mask);
    end
    rst = 1'b0;
    bus.start = 1'b0;
    exp_q.delete();
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (bus.done !== 1'b0) begin
        errors++;
        $display("FAIL rst_mid_no_done: got done=%b want 0", bus.done);
      end
    end
    bus.warp_retire = 1'b1;
    @(negedge clk);
    bus.warp_retire = 1'b0;
    run_block("after_rst", 32'd1, 32'd64, 32'd256, 3, 2);
  endtask

  initial begin
    bus.start = 1'b0; bus.block_id = '0; bus.block_dim = '0; bus.num_threads = '0;
    bus.warp_ready = 1'b0; bus.warp_retire = 1'b0;
    test_reset();
    test_basic();
    test_partial();
    test_backpressure();
    test_empty();
    test_rst_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/warp_dispatch.md
Name: warp_dispatch

Overview:
- Per-core stage directly downstream of the kernel block dispatcher.
- Accepts one thread block (start/block_id) and splits it into warps of WARP_SIZE threads.
- Issues the warps to the core's warp pipeline over a valid/ready handshake and counts warp retirements.
- Raises done back to the block dispatcher when every issued warp has retired.

Parameters:
- WARP_SIZE, 32, threads per warp; power of two.
- MAX_INFLIGHT, 4, max warps issued but not yet retired.
- WARP_ID_W, 8, width of the per-block warp index.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- start  in  1  block assigned; level, held by upstream until done observed
- block_id  in  32  block index, sampled on start in IDLE
- block_dim  in  32  threads per block
- num_threads  in  32  total kernel threads
- warp_valid  out  1  warp descriptor valid
- warp_ready  in  1  warp pipeline accepts descriptor
- warp_id  out  WARP_ID_W  warp index within block
- warp_base_tid  out  32  global thread id of lane 0
- warp_mask  out  WARP_SIZE  active-lane mask, bit i = lane i
- warp_retire  in  1  one-cycle pulse per retired warp
- busy  out  1  block in progress
- done  out  1  block complete

Behaviour:
- Reset rst: synchronous, active-high. It forces all of the following:
  - state=IDLE
  - warp_valid=0, done=0, busy=0
  - warp_id=0, warp_base_tid=0, warp_mask=0
  - inflight=0, issued=0, retired=0
- rst mid-operation abandons the block; no done is produced for it.
- States: IDLE, SETUP, ISSUE, DRAIN, DONE.
- IDLE: when start=1, latch block_id, block_dim and num_threads, then go to SETUP; busy=1 from the next cycle.
- SETUP (one cycle):
  - base = block_id*block_dim, truncated to 32 bits.
  - eff = 0 if base>=num_threads, else min(block_dim, num_threads-base).
  - num_warps = ceil(eff/WARP_SIZE).
  - If num_warps==0, go to DONE; otherwise go to ISSUE.
- ISSUE:
  - Drive warp_valid=1 when inflight<MAX_INFLIGHT.
  - Descriptor fields:
    - warp_id = issued.
    - warp_base_tid = base + issued*WARP_SIZE.
    - warp_mask = all ones, except for the last warp, where the low (eff - issued*WARP_SIZE) bits are set.
  - Transfer occurs on warp_valid && warp_ready: issued and inflight increment.
  - While warp_valid=1 and warp_ready=0, all descriptor fields are held stable.
  - warp_valid is never withdrawn before the transfer.
  - When issued reaches num_warps, warp_valid drops in the same cycle as the final transfer and the state goes to DRAIN.
  - When inflight==MAX_INFLIGHT, warp_valid=0 until a retire occurs.
- Issue latency: start sampled in cycle N gives warp_valid=1 in cycle N+2, provided num_warps>0.
- warp_retire handling (any state):
  - If inflight>0: inflight decrements and retired increments.
  - If inflight==0: the pulse is ignored and no counters change.
  - Transfer and retire in the same cycle: inflight unchanged, issued and retired both increment.
- DRAIN: when retired==num_warps, go to DONE.
- DONE:
  - done=1, busy=0.
  - Held until start=0 is sampled, then go to IDLE with done=0 on the next cycle.
  - A new start is accepted only from IDLE, so a block is never taken while done=1.
- Width rules:
  - Counters are WARP_ID_W bits wide.
  - num_warps is saturated to 2^WARP_ID_W-1.
  - Arithmetic is modulo 2^32; no overflow flag.

Optional Feature:
- Macro: WARP_DISPATCH_STATS_EN.
- When defined, adds output stall_cycles[31:0]:
  - Counts cycles with warp_valid=1 and warp_ready=0, plus cycles in ISSUE blocked by inflight==MAX_INFLIGHT.
  - Cleared on the IDLE→SETUP transition and by rst; saturates at 0xFFFFFFFF.
- When not defined, the port and its counter are absent; all other behaviour is identical.

Test Plan:
- block_id=1, block_dim=64, num_threads=256, warp_ready=1, retire 3 cycles after each issue → 2 warps: (id 0, base 64, mask 0xFFFFFFFF) and (id 1, base 96, mask 0xFFFFFFFF); done=1 one cycle after the 2nd retire.
- block_id=0, block_dim=100, num_threads=1000 → 4 warps with bases 0/32/64/96; the last mask is 0x0000000F.
- block_id=1, block_dim=128, num_threads=200 → eff=72; 3 warps with bases 128/160/192; masks 0xFFFFFFFF, 0xFFFFFFFF, 0x000000FF.
- Backpressure, block_dim=256, no retires, warp_ready low for 5 cycles:
  - warp_valid and descriptor are held constant while warp_ready is low.
  - Exactly 4 warps issue, then warp_valid=0.
  - A single retire releases warp 4.
  - With STATS_EN, stall_cycles counts the stalled cycles exactly.
- block_dim=0, or block_id=4 with block_dim=64 and num_threads=256 → no warp_valid ever; done=1 in cycle N+2; start low → done=0 the next cycle.
- rst asserted in ISSUE after 2 transfers → the next cycle has every output at its reset value. A fresh start then issues from warp_id 0. A stray warp_retire while inflight==0 is ignored.
